// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: piece encodings, grid/preview geometry and spawn location.
// A preview cell holds piece type + 1, so 0 always means empty.
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_S = 3'd3,
        PIECE_Z = 3'd4,
        PIECE_J = 3'd5,
        PIECE_L = 3'd6
    } piece_e;

    localparam logic [7:0] NEXT_PIECE_BASE_ADDR = 8'd240;
    localparam int         PREVIEW_W            = 3;
    localparam int         PREVIEW_CELLS        = 12;
    localparam int         FIELD_W              = 10;
    localparam logic [7:0] SPAWN_BASE_ADDR      = 8'd4;

    function automatic logic [2:0] cell_to_type(input logic [2:0] cell_lsbs);
        return cell_lsbs - 3'd1;
    endfunction

endpackage

// File: rtl/preview_to_field_addr.sv
// Combinational map of a row-major preview index to its playfield address at the spawn point.
// Zero latency; the 8-bit result wraps modulo 256.
module preview_to_field_addr
    import tetris_pkg::*;
(
    input  logic [3:0] idx,
    output logic [7:0] field_addr
);

    logic [3:0] row;
    logic [3:0] col;

    always_comb begin
        row        = idx / 4'(PREVIEW_W);
        col        = idx % 4'(PREVIEW_W);
        field_addr = SPAWN_BASE_ADDR + 8'(row) * 8'(FIELD_W) + 8'(col);
    end

endmodule

// File: rtl/next_piece_loader.sv
// Loads the next piece from the grid preview region into playfield spawn addresses; start->loaded is 14 cycles
// (26 with NEXT_PIECE_LOADER_CLEAR_EN, which also wipes the preview). No backpressure: start is ignored while busy.
module next_piece_loader
    import tetris_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       loaded,
    output logic       error,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [2:0] piece_type,
    output logic [7:0] piece_addr_1,
    output logic [7:0] piece_addr_2,
    output logic [7:0] piece_addr_3,
    output logic [7:0] piece_addr_4
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef NEXT_PIECE_LOADER_CLEAR_EN
    localparam logic [2:0] ST_CLEAR = 3'd4;
`endif

    localparam logic [3:0] LAST_IDX = 4'(PREVIEW_CELLS - 1);

    logic [2:0]      state_q, state_d;
    logic [3:0]      k_q, k_d;
    logic            cap_vld_q, cap_vld_d;
    logic [3:0]      cap_idx_q, cap_idx_d;
    logic [2:0]      found_q, found_d;
    logic [7:0]      first_q, first_d;
    logic            err_q, err_d;
    logic [2:0]      type_q, type_d;
    logic [3:0][7:0] addr_q, addr_d;
    logic [7:0]      cell_addr;

    preview_to_field_addr u_map (
        .idx        (cap_idx_q),
        .field_addr (cell_addr)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        found_d   = found_q;
        first_d   = first_q;
        err_d     = err_q;
        type_d    = type_q;
        addr_d    = addr_q;
        cap_vld_d = (state_q == ST_READ);
        cap_idx_d = k_q;

        // cap_* tags the read issued last cycle, which is what mem_rdata carries now
        if (cap_vld_q && (mem_rdata != 8'd0)) begin
            if (found_q < 3'd4) begin
                addr_d[found_q[1:0]] = cell_addr;
            end
            if (found_q == 3'd0) begin
                type_d  = cell_to_type(mem_rdata[2:0]);
                first_d = mem_rdata;
            end else if (mem_rdata != first_q) begin
                err_d = 1'b1;
            end
            if (mem_rdata > 8'd7) begin
                err_d = 1'b1;
            end
            if (found_q != 3'd5) begin
                found_d = found_q + 3'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    k_d     = 4'd0;
                    found_d = 3'd0;
                    first_d = 8'd0;
                    err_d   = 1'b0;
                    type_d  = 3'd0;
                    addr_d  = '0;
                end
            end
            ST_READ: begin
                k_d = k_q + 4'd1;
                if (k_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    k_d     = 4'd0;
                end
            end
            ST_DRAIN: begin
`ifdef NEXT_PIECE_LOADER_CLEAR_EN
                state_d = ST_CLEAR;
`else
                state_d = ST_DONE;
`endif
                // the shape check must already be reflected in error while loaded is high
                if (found_d != 3'd4) begin
                    err_d = 1'b1;
                end
            end
`ifdef NEXT_PIECE_LOADER_CLEAR_EN
            ST_CLEAR: begin
                k_d = k_q + 4'd1;
                if (k_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    k_d     = 4'd0;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= 4'd0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= 4'd0;
            found_q   <= 3'd0;
            first_q   <= 8'd0;
            err_q     <= 1'b0;
            type_q    <= 3'd0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            found_q   <= found_d;
            first_q   <= first_d;
            err_q     <= err_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
        end
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        loaded    = (state_q == ST_DONE);
        mem_wdata = 8'd0;
`ifdef NEXT_PIECE_LOADER_CLEAR_EN
        mem_we    = (state_q == ST_CLEAR);
        mem_addr  = ((state_q == ST_READ) || (state_q == ST_CLEAR)) ?
                    (NEXT_PIECE_BASE_ADDR + 8'(k_q)) : 8'd0;
`else
        mem_we    = 1'b0;
        mem_addr  = (state_q == ST_READ) ? (NEXT_PIECE_BASE_ADDR + 8'(k_q)) : 8'd0;
`endif
        error        = err_q;
        piece_type   = type_q;
        piece_addr_1 = addr_q[0];
        piece_addr_2 = addr_q[1];
        piece_addr_3 = addr_q[2];
        piece_addr_4 = addr_q[3];
    end

endmodule

// File: tb/tb_next_piece_loader.sv
// Bench for next_piece_loader: grid memory model, expected loads queued at start and checked at loaded.
module tb_next_piece_loader;

`ifdef NEXT_PIECE_LOADER_CLEAR_EN
    localparam int LOAD_CYC = 26;
    localparam int EXP_WE   = 12;
`else
    localparam int LOAD_CYC = 14;
    localparam int EXP_WE   = 0;
`endif

    typedef struct packed {
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] a4;
        logic [2:0] typ;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, loaded, error, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0] piece_type;
    logic [7:0] piece_addr_1, piece_addr_2, piece_addr_3, piece_addr_4;

    logic [7:0] gmem [256];
    logic       tb_we;
    logic [7:0] tb_addr, tb_wdata;
    logic [7:0] prev [12];

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc, we_cnt, we_bad, ld_cnt;

    always #5 clk = ~clk;

    next_piece_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .loaded       (loaded),
        .error        (error),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .piece_type   (piece_type),
        .piece_addr_1 (piece_addr_1),
        .piece_addr_2 (piece_addr_2),
        .piece_addr_3 (piece_addr_3),
        .piece_addr_4 (piece_addr_4)
    );

    always @(posedge clk) begin
        if (tb_we) gmem[tb_addr] <= tb_wdata;
        else if (mem_we) gmem[mem_addr] <= mem_wdata;
        mem_rdata <= gmem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (loaded) ld_cnt++;
        if (mem_we) begin
            we_cnt++;
            if ((mem_wdata != 8'd0) || (mem_addr != 8'(240 + we_cnt - 1))) we_bad++;
        end
    endtask

    task automatic clear_prev();
        for (int i = 0; i < 12; i++) prev[i] = 8'd0;
    endtask

    task automatic write_preview();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tb_we    = 1'b1;
            tb_addr  = 8'(240 + i);
            tb_wdata = prev[i];
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    function automatic exp_t model();
        exp_t       e;
        int         found;
        logic [7:0] first, v, ad;
        e     = '0;
        found = 0;
        first = 8'd0;
        for (int i = 0; i < 12; i++) begin
            v = prev[i];
            if (v != 8'd0) begin
                ad = 8'(4 + (i / 3) * 10 + i % 3);
                case (found)
                    0: e.a1 = ad;
                    1: e.a2 = ad;
                    2: e.a3 = ad;
                    3: e.a4 = ad;
                    default: ;
                endcase
                if (found == 0) begin
                    e.typ = 3'(v - 8'd1);
                    first = v;
                end else if (v != first) begin
                    e.err = 1'b1;
                end
                if (v > 8'd7) e.err = 1'b1;
                found++;
            end
        end
        if (found != 4) e.err = 1'b1;
        return e;
    endfunction

    function automatic exp_t mk(input int a1, input int a2, input int a3, input int a4,
                                input int typ, input int err);
        exp_t e;
        e.a1  = 8'(a1);
        e.a2  = 8'(a2);
        e.a3  = 8'(a3);
        e.a4  = 8'(a4);
        e.typ = 3'(typ);
        e.err = 1'(err);
        return e;
    endfunction

    task automatic compare_sb(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, "_addr1"}, piece_addr_1, e.a1);
            check({tag, "_addr2"}, piece_addr_2, e.a2);
            check({tag, "_addr3"}, piece_addr_3, e.a3);
            check({tag, "_addr4"}, piece_addr_4, e.a4);
            check({tag, "_type"},  piece_type,   e.typ);
            check({tag, "_error"}, error,        e.err);
        end
    endtask

    task automatic await_loaded(input string tag, input int exp_cyc);
        int budget;
        budget = 0;
        while (!loaded && budget < 200) begin
            step();
            budget++;
        end
        check({tag, "_loaded_seen"}, loaded, 1);
        if (loaded) begin
            check({tag, "_latency"}, cyc, exp_cyc);
            compare_sb(tag);
        end
    endtask

    task automatic do_load(input string tag, input bit poke);
        @(negedge clk);
        start  = 1'b1;
        cyc    = 0;
        we_cnt = 0;
        we_bad = 0;
        ld_cnt = 0;
        step();
        start = 1'b0;
        check({tag, "_addr_c1"}, mem_addr, 240);
        check({tag, "_busy_c1"}, busy, 1);
        check({tag, "_cleared_c1"}, {piece_addr_1, piece_addr_4, 5'd0, piece_type}, 0);
        while (cyc < 12) begin
            step();
            if (poke && cyc == 5) start = 1'b1;
            if (poke && cyc == 6) start = 1'b0;
        end
        check({tag, "_addr_c12"}, mem_addr, 251);
        await_loaded(tag, LOAD_CYC);
        step();
        check({tag, "_idle_after"}, busy, 0);
        check({tag, "_we_count"}, we_cnt, EXP_WE);
        check({tag, "_we_bad"}, we_bad, 0);
        if (poke) begin
            for (int i = 0; i < 4; i++) step();
            check({tag, "_no_extra_load"}, ld_cnt, 1);
        end
    endtask

    initial begin
        exp_t e;
        logic [7:0] v;
        rst   = 1'b1;
        start = 1'b0;
        tb_we = 1'b0;
        tb_addr  = 8'd0;
        tb_wdata = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_loaded", loaded, 0);
        check("rst_error", error, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_outs", {piece_addr_1, piece_addr_2, piece_addr_3, piece_addr_4, 5'd0, piece_type}, 0);
        rst = 1'b0;

        // I piece, then outputs must hold while idle
        clear_prev();
        prev[0] = 8'd1; prev[3] = 8'd1; prev[6] = 8'd1; prev[9] = 8'd1;
        write_preview();
        sbq.push_back(mk(4, 14, 24, 34, 0, 0));
        do_load("i_piece", 1'b0);
        repeat (3) step();
        check("idle_hold_addr4", piece_addr_4, 34);
        check("idle_hold_error", error, 0);

        // O piece with a start pulse while busy
        clear_prev();
        prev[6] = 8'd2; prev[7] = 8'd2; prev[9] = 8'd2; prev[10] = 8'd2;
        write_preview();
        sbq.push_back(mk(24, 25, 34, 35, 1, 0));
        do_load("o_piece", 1'b1);

        clear_prev();
        write_preview();
        sbq.push_back(mk(0, 0, 0, 0, 0, 1));
        do_load("empty", 1'b0);

        clear_prev();
        prev[0] = 8'd4; prev[4] = 8'd4; prev[6] = 8'd4; prev[7] = 8'd4; prev[10] = 8'd4;
        write_preview();
        sbq.push_back(mk(4, 15, 24, 25, 3, 1));
        do_load("five_cells", 1'b0);

        clear_prev();
        prev[0] = 8'd3; prev[1] = 8'd3; prev[2] = 8'd5; prev[4] = 8'd5;
        write_preview();
        sbq.push_back(mk(4, 5, 6, 15, 2, 1));
        do_load("mixed", 1'b0);

        // Reset in cycle 6 of READ
        clear_prev();
        prev[0] = 8'd1; prev[3] = 8'd1; prev[6] = 8'd1; prev[9] = 8'd1;
        write_preview();
        @(negedge clk);
        start  = 1'b1;
        cyc    = 0;
        ld_cnt = 0;
        step();
        start = 1'b0;
        while (cyc < 6) step();
        rst = 1'b1;
        step();
        check("midrst_busy", busy, 0);
        check("midrst_we", mem_we, 0);
        check("midrst_loaded", loaded, 0);
        check("midrst_addr1", piece_addr_1, 0);
        rst = 1'b0;
        repeat (30) step();
        check("midrst_no_load", ld_cnt, 0);

        // T piece, then the preview is cleared or intact depending on build
        clear_prev();
        prev[1] = 8'd3; prev[3] = 8'd3; prev[4] = 8'd3; prev[5] = 8'd3;
        write_preview();
        sbq.push_back(mk(5, 14, 15, 16, 2, 0));
        do_load("t_piece", 1'b0);
        for (int i = 0; i < 12; i++) begin
`ifdef NEXT_PIECE_LOADER_CLEAR_EN
            check($sformatf("preview_cleared_%0d", i), gmem[240 + i], 0);
`else
            check($sformatf("preview_intact_%0d", i), gmem[240 + i], prev[i]);
`endif
        end

        // start held high: second load begins right after return to IDLE
        write_preview();
        sbq.push_back(mk(5, 14, 15, 16, 2, 0));
`ifdef NEXT_PIECE_LOADER_CLEAR_EN
        sbq.push_back(mk(0, 0, 0, 0, 0, 1));
`else
        sbq.push_back(mk(5, 14, 15, 16, 2, 0));
`endif
        @(negedge clk);
        start = 1'b1;
        cyc   = 0;
        step();
        await_loaded("held1", LOAD_CYC);
        step();
        check("held_idle_gap", busy, 0);
        step();
        start = 1'b0;
        check("held_restart", busy, 1);
        await_loaded("held2", 2 * LOAD_CYC + 1);
        step();

        // randomised previews against the reference model
        for (int r = 0; r < 3; r++) begin
            v = 8'($urandom_range(1, 7));
            for (int i = 0; i < 12; i++) begin
                prev[i] = ($urandom_range(0, 2) == 0) ? v : 8'd0;
                if ($urandom_range(0, 9) == 0) prev[i] = 8'($urandom_range(1, 9));
            end
            write_preview();
            e = model();
            sbq.push_back(e);
            do_load($sformatf("rand%0d", r), 1'b0);
        end

        check("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
